// File: rtl/wbs_addr_pkg.sv
// Shared Wishbone address map for the accelerator windows, plus the readout
// FSM state enum and the index/row width helpers.
package wbs_addr_pkg;

   // Top byte of the address selects a window.
   localparam logic [31:0] WBS_ADDR_MASK  = 32'hFF00_0000;
   localparam logic [31:0] WBS_REG_ADDR   = 32'h3000_0000;
   localparam logic [31:0] WBS_QUERY_ADDR = 32'h3100_0000;
   localparam logic [31:0] WBS_LEAF_ADDR  = 32'h3200_0000;
   localparam logic [31:0] WBS_BEST_ADDR  = 32'h3300_0000;
   localparam logic [31:0] WBS_NODE_ADDR  = 32'h3400_0000;

   typedef enum logic [1:0] {
      BEST_IDLE = 2'd0,
      BEST_RD   = 2'd1,
      BEST_CAP  = 2'd2,
      BEST_ACK  = 2'd3
   } best_rd_state_t;

   // Width of one patch index: enough bits to name every patch in the tree.
   function automatic int idx_w_calc(input int num_leaves, input int leaf_size);
      return $clog2(num_leaves * leaf_size);
   endfunction

   // Width of one best-memory row: K indices packed side by side.
   function automatic int row_w_calc(input int k, input int idx_w);
      return k * idx_w;
   endfunction

endpackage

// File: rtl/wbs_best_reader_if.sv
// Bus bundle for wbs_best_reader: Wishbone slave side, best-memory SRAM
// port and the accelerator write strobe used for cache invalidation.
interface wbs_best_reader_if #(
   parameter int ADDR_W = 9,
   parameter int ROW_W  = 36
);
   logic              wbs_stb_i;
   logic              wbs_cyc_i;
   logic              wbs_we_i;
   logic [31:0]       wbs_adr_i;
   logic              wbs_ack_o;
   logic [31:0]       wbs_dat_o;
   logic              best_mem_csb0;
   logic              best_mem_web0;
   logic [ADDR_W-1:0] best_mem_addr0;
   logic [ROW_W-1:0]  best_mem_rdata0;
   logic              acc_wr_i;

   modport slave (
      input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, best_mem_rdata0, acc_wr_i,
      output wbs_ack_o, wbs_dat_o, best_mem_csb0, best_mem_web0, best_mem_addr0
   );

   modport master (
      output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_adr_i, best_mem_rdata0, acc_wr_i,
      input  wbs_ack_o, wbs_dat_o, best_mem_csb0, best_mem_web0, best_mem_addr0
   );
endinterface

// File: rtl/best_row_cache.sv
// One-row cache of the last best-memory row read: tag, valid and row data.
// Any invalidation seen while a fill is in flight keeps the filled row
// invalid, so a row that may have been rewritten is never served.
module best_row_cache #(
   parameter int ADDR_W = 9,
   parameter int ROW_W  = 36
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] lookup_row,
   input  logic              fill_start,
   input  logic              cap_en,
   input  logic [ADDR_W-1:0] cap_row,
   input  logic [ROW_W-1:0]  cap_data,
   input  logic              inval,
   input  logic              acc_wr,
   output logic              hit,
   output logic [ROW_W-1:0]  row_data
);
   logic              valid;
   logic              stale;
   logic [ADDR_W-1:0] tag;

   // Accelerator write in the decision cycle forces a miss.
   assign hit = valid & (tag == lookup_row) & ~acc_wr;

   // Tag/data fill on capture; stale remembers invalidations during a fill.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid    <= 1'b0;
         stale    <= 1'b0;
         tag      <= '0;
         row_data <= '0;
      end else begin
         if (fill_start)
            stale <= inval;
         else if (inval)
            stale <= 1'b1;

         if (cap_en) begin
            tag      <= cap_row;
            row_data <= cap_data;
            valid    <= ~(stale | inval);
         end else if (inval) begin
            valid <= 1'b0;
         end
      end
   end
endmodule

// File: rtl/wbs_best_reader.sv
// Wishbone readout slave for the k-best result memory (0x3300_0000 window).
// Each query row returns as two words: lower = row[31:0], upper = the
// zero-extended remaining bits. Optional one-row cache under the macro
// BEST_READ_CACHE_EN; without it every in-range read goes to the SRAM.
module wbs_best_reader
   import wbs_addr_pkg::*;
#(
   parameter int LEAF_SIZE  = 8,
   parameter int NUM_LEAVES = 64,
   parameter int ROW_SIZE   = 24,
   parameter int COL_SIZE   = 17,
   parameter int K          = 4,
   parameter int NUM_QUERYS = ROW_SIZE * COL_SIZE,
   parameter int IDX_W      = idx_w_calc(NUM_LEAVES, LEAF_SIZE),
   parameter int ROW_W      = row_w_calc(K, IDX_W),
   parameter int ADDR_W     = $clog2(NUM_QUERYS)
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   wbs_best_reader_if.slave  bus
);
   localparam logic [1:0] S_IDLE = BEST_IDLE;
   localparam logic [1:0] S_RD   = BEST_RD;
   localparam logic [1:0] S_CAP  = BEST_CAP;
   localparam logic [1:0] S_ACK  = BEST_ACK;

   localparam logic [ADDR_W:0] NQ_LIM = (ADDR_W + 1)'(NUM_QUERYS);

   logic [1:0]        state;
   logic              half_q;
   logic              sel;
   logic [ADDR_W-1:0] row_req;
   logic              half_req;
   logic              in_range;
   logic              hit;
   logic [ROW_W-1:0]  hit_row;

   // Upper half carries the bits above 31, zero-extended to a full word.
   function automatic logic [31:0] pick(input logic [ROW_W-1:0] r, input logic h);
      return h ? {{(64 - ROW_W){1'b0}}, r[ROW_W-1:32]} : r[31:0];
   endfunction

   assign sel      = bus.wbs_cyc_i & bus.wbs_stb_i &
                     ((bus.wbs_adr_i & WBS_ADDR_MASK) == WBS_BEST_ADDR);
   assign row_req  = bus.wbs_adr_i[ADDR_W:1];
   assign half_req = bus.wbs_adr_i[0];
   assign in_range = {1'b0, row_req} < NQ_LIM;

   // Address bits between the row field and the window byte are don't-care.
   logic unused_adr;
   assign unused_adr = ^bus.wbs_adr_i[23:ADDR_W+1];

   // This block never writes the best memory.
   assign bus.best_mem_web0 = 1'b1;

`ifdef BEST_READ_CACHE_EN
   logic fill_start;
   logic inval;

   assign inval      = bus.acc_wr_i | ((state == S_IDLE) & sel & bus.wbs_we_i);
   assign fill_start = (state == S_IDLE) & sel & ~bus.wbs_we_i & in_range & ~hit;

   best_row_cache #(
      .ADDR_W (ADDR_W),
      .ROW_W  (ROW_W)
   ) u_cache (
      .clk        (wb_clk_i),
      .rst        (wb_rst_i),
      .lookup_row (row_req),
      .fill_start (fill_start),
      .cap_en     (state == S_CAP),
      .cap_row    (bus.best_mem_addr0),
      .cap_data   (bus.best_mem_rdata0),
      .inval      (inval),
      .acc_wr     (bus.acc_wr_i),
      .hit        (hit),
      .row_data   (hit_row)
   );
`else
   logic unused_acc;
   assign unused_acc = bus.acc_wr_i;
   assign hit        = 1'b0;
   assign hit_row    = '0;
`endif

   // Read FSM: IDLE decodes, RD pulses the SRAM, CAP captures, ACK answers.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state              <= S_IDLE;
         half_q             <= 1'b0;
         bus.wbs_ack_o      <= 1'b0;
         bus.wbs_dat_o      <= '0;
         bus.best_mem_csb0  <= 1'b1;
         bus.best_mem_addr0 <= '0;
      end else begin
         bus.wbs_ack_o     <= 1'b0;
         bus.best_mem_csb0 <= 1'b1;
         case (state)
            S_IDLE: begin
               if (sel) begin
                  if (bus.wbs_we_i) begin
                     state         <= S_ACK;
                     bus.wbs_ack_o <= 1'b1;
                  end else if (!in_range) begin
                     state         <= S_ACK;
                     bus.wbs_ack_o <= 1'b1;
                     bus.wbs_dat_o <= '0;
                  end else if (hit) begin
                     state         <= S_ACK;
                     bus.wbs_ack_o <= 1'b1;
                     bus.wbs_dat_o <= pick(hit_row, half_req);
                  end else begin
                     state              <= S_RD;
                     bus.best_mem_csb0  <= 1'b0;
                     bus.best_mem_addr0 <= row_req;
                     half_q             <= half_req;
                  end
               end
            end
            S_RD:  state <= S_CAP;
            S_CAP: begin
               state         <= S_ACK;
               bus.wbs_ack_o <= 1'b1;
               bus.wbs_dat_o <= pick(bus.best_mem_rdata0, half_q);
            end
            S_ACK:   state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_wbs_best_reader.sv
// Self-checking bench for wbs_best_reader: SRAM model, behavioural model of
// the readout rules (latency, SRAM accesses, returned word, cache state),
// directed scenarios and a randomized transaction run.
module tb_wbs_best_reader;
   localparam int NQ = 408;
`ifdef BEST_READ_CACHE_EN
   localparam bit CACHE = 1'b1;
`else
   localparam bit CACHE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   wbs_best_reader_if bus ();

   wbs_best_reader dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   // SRAM: data appears the cycle after csb0 low, garbage otherwise.
   logic [35:0] mem [0:NQ-1];
   always @(posedge clk) begin
      if (!bus.best_mem_csb0 && bus.best_mem_addr0 < 9'(NQ))
         bus.best_mem_rdata0 <= mem[bus.best_mem_addr0];
      else
         bus.best_mem_rdata0 <= 36'({$urandom, $urandom});
   end

   // Model state: what the slave should currently hold.
   bit          m_valid;
   int          m_tag;
   logic [31:0] m_dat;

   function automatic logic [31:0] word_of(input logic [35:0] r, input logic h);
      logic [35:0] s;
      s = r >> 32;
      return h ? 32'(s) : r[31:0];
   endfunction

   task automatic predict(input logic [31:0] adr, input logic we, input logic acc_mid,
                          output int lat, output int ncsb, output int caddr,
                          output logic [31:0] dat);
      int   row;
      logic half;
      row  = int'((adr >> 1) & 32'h1FF);
      half = adr[0];
      caddr = row;
      if (we) begin
         lat = 1; ncsb = 0; dat = m_dat; m_valid = 0;
      end else if (row >= NQ) begin
         lat = 1; ncsb = 0; dat = 0; m_dat = 0;
      end else if (CACHE && m_valid && m_tag == row) begin
         lat = 1; ncsb = 0; dat = word_of(mem[row], half); m_dat = dat;
      end else begin
         lat = 3; ncsb = 1; dat = word_of(mem[row], half); m_dat = dat;
         m_valid = !acc_mid; m_tag = row;
      end
   endtask

   task automatic txn(input logic [31:0] adr, input logic we, input logic acc_mid,
                      output int lat, output int ncsb, output int caddr,
                      output logic [31:0] dat, output logic ack_after);
      lat = -1; ncsb = 0; caddr = -1; dat = '0; ack_after = 1'b0;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i = we;    bus.wbs_adr_i = adr;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (acc_mid) bus.acc_wr_i = (k == 1);
         if (!bus.best_mem_csb0) begin ncsb++; caddr = int'(bus.best_mem_addr0); end
         if (bus.wbs_ack_o) begin lat = k; dat = bus.wbs_dat_o; break; end
      end
      bus.acc_wr_i = 1'b0;
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      @(negedge clk);
      ack_after = bus.wbs_ack_o;
   endtask

   task automatic pulse_acc(input int row);
      @(negedge clk);
      mem[row] = 36'({$urandom, $urandom});
      bus.acc_wr_i = 1'b1;
      @(negedge clk);
      bus.acc_wr_i = 1'b0;
      m_valid = 0;
   endtask

   task automatic test_reset;
      @(negedge clk);
      total += 5;
      if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL reset_ack got=%b want=0", bus.wbs_ack_o); end
      if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat got=%h want=0", bus.wbs_dat_o); end
      if (bus.best_mem_csb0 !== 1'b1) begin bad++; $display("FAIL reset_csb0 got=%b want=1", bus.best_mem_csb0); end
      if (bus.best_mem_web0 !== 1'b1) begin bad++; $display("FAIL reset_web0 got=%b want=1", bus.best_mem_web0); end
      if (bus.best_mem_addr0 !== 9'h0) begin bad++; $display("FAIL reset_addr0 got=%h want=0", bus.best_mem_addr0); end
   endtask

   // Scripted sequence with literal expected words where the scenario fixes them.
   task automatic test_directed;
      logic [31:0] adr  [6];
      logic        we   [6];
      logic [31:0] lit  [6];
      bit          chk  [6];
      int el, en, ec, ol, on, oc;
      logic [31:0] ed, od;
      logic oa;
      mem[2] = 36'hA_1234_5678;
      adr[0] = 32'h3300_0004; we[0] = 0; lit[0] = 32'h1234_5678; chk[0] = 1;
      adr[1] = 32'h3300_0005; we[1] = 0; lit[1] = 32'h0000_000A; chk[1] = 1;
      adr[2] = 32'h3300_0004; we[2] = 1; lit[2] = 32'h0000_000A; chk[2] = 1;
      adr[3] = 32'h3300_0004; we[3] = 0; lit[3] = 32'h1234_5678; chk[3] = 1;
      adr[4] = 32'h3300_0330; we[4] = 0; lit[4] = 32'h0;         chk[4] = 1;
      adr[5] = 32'h3300_03FF; we[5] = 0; lit[5] = 32'h0;         chk[5] = 1;
      for (int i = 0; i < 6; i++) begin
         predict(adr[i], we[i], 1'b0, el, en, ec, ed);
         txn(adr[i], we[i], 1'b0, ol, on, oc, od, oa);
         total += 4;
         if (ol != el) begin bad++; $display("FAIL dir%0d_latency got=%0d want=%0d", i, ol, el); end
         if (on != en) begin bad++; $display("FAIL dir%0d_csb_pulses got=%0d want=%0d", i, on, en); end
         if (od !== ed) begin bad++; $display("FAIL dir%0d_data got=%h want=%h", i, od, ed); end
         if (oa !== 1'b0) begin bad++; $display("FAIL dir%0d_ack_width got=%b want=0", i, oa); end
         if (en == 1) begin
            total++;
            if (oc != ec) begin bad++; $display("FAIL dir%0d_addr0 got=%0d want=%0d", i, oc, ec); end
         end
         if (chk[i]) begin
            total++;
            if (od !== lit[i]) begin bad++; $display("FAIL dir%0d_literal got=%h want=%h", i, od, lit[i]); end
         end
      end
   endtask

   // Accelerator write between halves, and during an in-flight read.
   task automatic test_acc_inval;
      int el, en, ec, ol, on, oc;
      logic [31:0] ed, od;
      logic oa;
      predict(32'h3300_000A, 1'b0, 1'b0, el, en, ec, ed);
      txn(32'h3300_000A, 1'b0, 1'b0, ol, on, oc, od, oa);
      pulse_acc(5);
      predict(32'h3300_000B, 1'b0, 1'b0, el, en, ec, ed);
      txn(32'h3300_000B, 1'b0, 1'b0, ol, on, oc, od, oa);
      total += 3;
      if (ol != 3) begin bad++; $display("FAIL acc_between_latency got=%0d want=3", ol); end
      if (on != 1) begin bad++; $display("FAIL acc_between_csb got=%0d want=1", on); end
      if (od !== ed) begin bad++; $display("FAIL acc_between_data got=%h want=%h", od, ed); end
      predict(32'h3300_000E, 1'b0, 1'b1, el, en, ec, ed);
      txn(32'h3300_000E, 1'b0, 1'b1, ol, on, oc, od, oa);
      total += 2;
      if (ol != 3) begin bad++; $display("FAIL acc_inflight_latency got=%0d want=3", ol); end
      if (od !== ed) begin bad++; $display("FAIL acc_inflight_data got=%h want=%h", od, ed); end
      predict(32'h3300_000F, 1'b0, 1'b0, el, en, ec, ed);
      txn(32'h3300_000F, 1'b0, 1'b0, ol, on, oc, od, oa);
      total += 2;
      if (ol != 3) begin bad++; $display("FAIL acc_inflight_reread got=%0d want=3", ol); end
      if (od !== ed) begin bad++; $display("FAIL acc_inflight_redata got=%h want=%h", od, ed); end
   endtask

   // Other windows must be ignored entirely.
   task automatic test_other_window;
      int acks, lows;
      acks = 0; lows = 0;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
      bus.wbs_adr_i = 32'h3200_0004;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.wbs_ack_o) acks++;
         if (!bus.best_mem_csb0) lows++;
      end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      total += 2;
      if (acks != 0) begin bad++; $display("FAIL other_window_ack got=%0d want=0", acks); end
      if (lows != 0) begin bad++; $display("FAIL other_window_csb got=%0d want=0", lows); end
   endtask

   // Held request: one ack every other cycle, never adjacent.
   task automatic test_back_to_back;
      int acks, adj;
      logic prev;
      acks = 0; adj = 0; prev = 1'b0;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
      bus.wbs_adr_i = 32'h3300_0331;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (bus.wbs_ack_o) acks++;
         if (bus.wbs_ack_o && prev) adj++;
         prev = bus.wbs_ack_o;
      end
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      m_dat = 0;
      @(negedge clk);
      @(negedge clk);
      total += 3;
      if (acks != 4) begin bad++; $display("FAIL b2b_ack_count got=%0d want=4", acks); end
      if (adj != 0) begin bad++; $display("FAIL b2b_adjacent got=%0d want=0", adj); end
      if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL b2b_data got=%h want=0", bus.wbs_dat_o); end
   endtask

   // Reset in RD aborts the read with no ack; the next read is a clean miss.
   task automatic test_reset_in_rd;
      int acks, el, en, ec, ol, on, oc;
      logic [31:0] ed, od;
      logic oa;
      acks = 0;
      @(negedge clk);
      bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b0;
      bus.wbs_adr_i = 32'h3300_0010;
      @(negedge clk);
      total++;
      if (bus.best_mem_csb0 !== 1'b0) begin bad++; $display("FAIL rst_rd_entered got=%b want=0", bus.best_mem_csb0); end
      rst = 1'b1;
      @(negedge clk);
      total += 3;
      if (bus.wbs_ack_o !== 1'b0) begin bad++; $display("FAIL rst_rd_ack got=%b want=0", bus.wbs_ack_o); end
      if (bus.best_mem_csb0 !== 1'b1) begin bad++; $display("FAIL rst_rd_csb0 got=%b want=1", bus.best_mem_csb0); end
      if (bus.wbs_dat_o !== 32'h0) begin bad++; $display("FAIL rst_rd_dat got=%h want=0", bus.wbs_dat_o); end
      rst = 1'b0;
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0;
      m_valid = 0; m_dat = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (bus.wbs_ack_o) acks++;
      end
      total++;
      if (acks != 0) begin bad++; $display("FAIL rst_rd_late_ack got=%0d want=0", acks); end
      predict(32'h3300_0004, 1'b0, 1'b0, el, en, ec, ed);
      txn(32'h3300_0004, 1'b0, 1'b0, ol, on, oc, od, oa);
      total += 2;
      if (ol != 3) begin bad++; $display("FAIL rst_rd_after_latency got=%0d want=3", ol); end
      if (od !== ed) begin bad++; $display("FAIL rst_rd_after_data got=%h want=%h", od, ed); end
   endtask

   task automatic test_random;
      int rows [6];
      int el, en, ec, ol, on, oc, row;
      logic [31:0] ed, od, adr;
      logic oa, we, am;
      rows[0] = 0; rows[1] = 1; rows[2] = 3; rows[3] = 407; rows[4] = 408; rows[5] = 500;
      for (int i = 0; i < 80; i++) begin
         row = rows[$urandom_range(5)];
         adr = 32'h3300_0000 | 32'(row << 1) | 32'($urandom_range(1));
         we  = ($urandom_range(7) == 0);
         am  = !we && ($urandom_range(9) == 0);
         if ($urandom_range(7) == 0) pulse_acc(rows[$urandom_range(3)]);
         predict(adr, we, am, el, en, ec, ed);
         txn(adr, we, am, ol, on, oc, od, oa);
         total += 4;
         if (ol != el) begin bad++; $display("FAIL rnd%0d_latency adr=%h got=%0d want=%0d", i, adr, ol, el); end
         if (on != en) begin bad++; $display("FAIL rnd%0d_csb_pulses adr=%h got=%0d want=%0d", i, adr, on, en); end
         if (od !== ed) begin bad++; $display("FAIL rnd%0d_data adr=%h got=%h want=%h", i, adr, od, ed); end
         if (oa !== 1'b0) begin bad++; $display("FAIL rnd%0d_ack_width got=%b want=0", i, oa); end
         if (en == 1) begin
            total++;
            if (oc != ec) begin bad++; $display("FAIL rnd%0d_addr0 got=%0d want=%0d", i, oc, ec); end
         end
      end
   endtask

   initial begin
      bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
      bus.wbs_adr_i = '0;   bus.acc_wr_i = 1'b0;
      for (int i = 0; i < NQ; i++) mem[i] = 36'({$urandom, $urandom});
      m_valid = 0; m_tag = 0; m_dat = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      test_reset();
      test_directed();
      test_acc_inval();
      test_other_window();
      test_back_to_back();
      test_reset_in_rd();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
